// File: rtl/shift_rows_ctrl.sv
// shift_rows_ctrl: sequences the 32-bit ShiftRows row unit over the four rows
// of a captured 128-bit AES state and returns the reassembled result.
// Optional feature macro: SHIFT_ROWS_CTRL_INV_EN adds the inv port, which
// selects InvShiftRows by driving row_idx = (4 - r) mod 4.
module shift_rows_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [1:0]   row_idx,
    output logic [31:0]  row_data,
    output logic         row_start,
    input  logic         row_done,
`ifdef SHIFT_ROWS_CTRL_INV_EN
    input  logic [31:0]  row_result,
    input  logic         inv
`else
    input  logic [31:0]  row_result
`endif
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned ROW_W   = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NCOL    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_cnt;
    logic [STATE_W-1:0] r_data;
    logic [ROW_W-1:0]   w_row_sel;
    logic [1:0]         w_rot;
`ifdef SHIFT_ROWS_CTRL_INV_EN
    logic               r_inv;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the last row's done replaces the 3 -> 0 counter wrap
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid)                   w_next = RUN;
            RUN:  if (row_done && r_cnt == 2'd3) w_next = OUT;
            OUT:  if (out_ready)                 w_next = IDLE;
            default:                             w_next = IDLE;
        endcase
    end

    // Row counter, state capture and per-row write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_data <= '0;
`ifdef SHIFT_ROWS_CTRL_INV_EN
            r_inv  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= in_state;
                        r_cnt  <= 2'd0;
`ifdef SHIFT_ROWS_CTRL_INV_EN
                        r_inv  <= inv;
`endif
                    end
                end
                RUN: begin
                    if (row_done) begin
                        for (int c = 0; c < int'(NCOL); c++) begin
                            r_data[int'(STATE_W) - 1 - int'(BYTE_W) * (int'(r_cnt) + 4 * c) -: BYTE_W]
                                <= row_result[int'(ROW_W) - 1 - int'(BYTE_W) * c -: BYTE_W];
                        end
                        if (r_cnt != 2'd3) begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gather row r of the state register as {s(r,0), s(r,1), s(r,2), s(r,3)}
    always_comb begin
        w_row_sel = '0;
        for (int c = 0; c < int'(NCOL); c++) begin
            w_row_sel[int'(ROW_W) - 1 - int'(BYTE_W) * c -: BYTE_W] =
                r_data[int'(STATE_W) - 1 - int'(BYTE_W) * (int'(r_cnt) + 4 * c) -: BYTE_W];
        end
    end

    // Rotation amount handed to the row unit
    always_comb begin
`ifdef SHIFT_ROWS_CTRL_INV_EN
        w_rot = r_inv ? (2'd0 - r_cnt) : r_cnt;
`else
        w_rot = r_cnt;
`endif
    end

    // Output decode from registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        row_start = 1'b0;
        row_idx   = 2'd0;
        row_data  = '0;
        case (r_state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                row_start = 1'b1;
                row_idx   = w_rot;
                row_data  = w_row_sel;
            end
            OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_state = r_data;

endmodule

// File: doc/shift_rows_ctrl.md
# shift_rows_ctrl

Sequencer for the 32-bit ShiftRows row unit inside the AES-128 round datapath. It accepts a full 128-bit AES state over a valid/ready handshake and drives the row unit once per row, rows 0 to 3. It reassembles the four shifted rows into a 128-bit result and presents that result over a second valid/ready handshake. It sits between the SubBytes stage and the MixColumns stage and is the only master of the row unit.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state (high only in IDLE)
- in_state  input  128  AES state, column-major; byte k = in_state[127-8k -: 8] = s(k mod 4, k div 4)
- out_valid  output  1  out_state holds the finished result
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  shifted state, same byte layout
- row_idx  output  2  row index driven to the row unit
- row_data  output  32  row word {s(r,0), s(r,1), s(r,2), s(r,3)}
- row_start  output  1  request to the row unit
- row_done  input  1  row unit result valid
- row_result  input  32  row unit output, row rotated left by row_idx bytes
- inv  input  1  inverse ShiftRows select; present only with SHIFT_ROWS_CTRL_INV_EN

## Operation
- The FSM has three states: IDLE, RUN, OUT. There is a 2-bit row counter `r` and a 128-bit state register.
- IDLE:
  - in_ready=1.
  - When in_valid and in_ready are both high at a clock edge: capture in_state, and capture inv if the macro is enabled. Set r=0 and go to RUN.
- RUN:
  - row_start=1; row_idx=r; row_data is row r of the captured state.
  - With row_done=1 at an edge: write row_result bytes back into state positions r, r+4, r+8, r+12, in order.
  - After that write, if r==3 go to OUT; otherwise r=r+1.
  - With row_done=0: hold all outputs and stall indefinitely. The block has no timeout.
- OUT:
  - out_valid=1; out_state is the state register.
  - When out_valid and out_ready are both high at an edge, go to IDLE. out_state stays unchanged until the next capture.
- row_done is ignored outside RUN.
- in_valid during RUN or OUT is not accepted; in_ready=0 in those states.
- Counter wrap: r increments only from 0 to 2. The update that would take r from 3 to 0 is replaced by the transition to OUT, and r is reset to 0 on entry to RUN.
- Reset values: FSM=IDLE, r=0, state register=0, in_ready=1, out_valid=0, out_state=0, row_start=0, row_idx=0, row_data=0.
- row_data and row_idx are 0 whenever the FSM is not in RUN.
- Reset asserted mid-RUN or mid-OUT aborts the operation immediately (asynchronous) and discards the partial state.

## Timing
- When the row unit returns row_done in the same cycle as row_start, each row takes one cycle.
- Acceptance edge = E0. Rows are written at E1 through E4. out_valid is high from just after E4 through the edge where out_ready is sampled high.
- Minimum throughput is one state per 6 cycles: accept, 4 rows, output handshake, then back to IDLE.
- Each additional row_done wait cycle adds one cycle of latency.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid or out_ready to any output, except in_ready, which is state-decoded.

## Configuration
- SHIFT_ROWS_CTRL_INV_EN defined:
  - The inv port exists and is captured at acceptance.
  - With inv=1, row_idx = (4 - r) mod 4, giving row indices 0, 3, 2, 1. Each row is rotated right by r bytes, which is InvShiftRows.
  - With inv=0, behaviour is identical to the undefined case.
- SHIFT_ROWS_CTRL_INV_EN undefined: the inv port is absent and row_idx = r always (forward ShiftRows only).

## Test plan
The bench connects the combinational ShiftRows row unit (done = start) to the row_* ports.
- FIPS-197 vector: in_state=0xd42711aee0bf98f1b8b45de51e415230, out_ready=1 → out_state=0xd4bf5d30e0b452aeb84111f11e2798e5, out_valid rising exactly 4 cycles after acceptance.
- Identity pattern: in_state=0x000102030405060708090a0b0c0d0e0f → out_state=0x00050a0f04090e03080d02070c01060b.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid stays 1, out_state stable, in_ready=0. Release → one transfer, then in_ready=1.
- Stall: row unit model withholds row_done for 3 cycles on row 2 → row_idx=2 and row_data held stable; final result unchanged; latency 7 cycles.
- Reset mid-RUN after row 1 is written → all outputs at their reset values immediately. A new state accepted after reset produces the correct result.
- (SHIFT_ROWS_CTRL_INV_EN) inv=1 with in_state=0xd4bf5d30e0b452aeb84111f11e2798e5 → out_state=0xd42711aee0bf98f1b8b45de51e415230; row_idx sequence 0, 3, 2, 1.
